decode_stage: RTL and testbench

Parametrised RV32 instruction-decode stage with integrated register file, control decode, full immediate generation and a valid-tracked ID/EX pipeline register. It sits between the IF/ID register and the execute stage. It adds behaviour the first-generation decode block lacked: back-pressure hold from a multi-cycle EX, writeback refresh of held operands, x0-safe bypass, U-type immediates, and byte-offset branch/jump immediates.

---
 rtl/decode_pkg.sv | 67 ++++++
 rtl/decode_ctl.sv | 125 ++++++++++++
 rtl/decode_stage.sv | 184 ++++++++++++++++++
 tb/tb_decode_stage.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_pkg
// Description : Shared opcode encodings, ALUOp codes, the packed control
//               bundle and the RV32 immediate generator for decode_stage.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

    // RV32 base opcodes recognised by the decoder
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALUOp encodings consumed by the EX-stage ALU control
    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_R      = 2'b10;
    localparam logic [1:0] ALUOP_IMM    = 2'b11;

    // Control bundle carried through the ID/EX register
    typedef struct packed {
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
        logic       jal;
        logic       jalr;
        logic       lui;
        logic       auipc;
    } ctl_t;

    localparam ctl_t CTL_NOP = '0;

    // 32-bit sign-extended immediate; branch/jump offsets keep bit 0 = 0 so
    // they are byte offsets, U-type is already shifted into the upper bits.
    function automatic logic [31:0] gen_imm(input logic [31:0] inst);
        logic [31:0] imm;
        imm = '0;
        case (inst[6:0])
            OP_IMM, OP_LOAD, OP_JALR:
                imm = {{20{inst[31]}}, inst[31:20]};
            OP_STORE:
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OP_BRANCH:
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OP_JAL:
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            OP_LUI, OP_AUIPC:
                imm = {inst[31:12], 12'b0};
            default:
                imm = '0;
        endcase
        return imm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_ctl.sv
`default_nettype none
// ============================================================================
// Module      : decode_ctl
// Description : Combinational opcode-to-control decode. With the
//               ILLEGAL_DETECT_EN macro defined it also flags unknown
//               opcodes, bad R-type funct7 and out-of-range register fields,
//               forcing the control bundle to zero for such instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_ctl
    import decode_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic [31:0] i_instruction,
    output ctl_t        o_ctl,
    output logic        o_illegal
);

    localparam logic [5:0] c_nreg = 6'(NREG);

    logic [6:0] w_opcode;
    ctl_t       w_ctl_raw;
    logic       w_known;
    logic       w_unused;

    assign w_opcode = i_instruction[6:0];

    // Opcode decode; anything not listed leaves every control bit low
    always_comb begin
        w_ctl_raw = CTL_NOP;
        w_known   = 1'b1;
        case (w_opcode)
            OP_R: begin
                w_ctl_raw.regwrite = 1'b1;
                w_ctl_raw.aluop    = ALUOP_R;
            end
            OP_IMM: begin
                w_ctl_raw.alusrc   = 1'b1;
                w_ctl_raw.regwrite = 1'b1;
                w_ctl_raw.aluop    = ALUOP_IMM;
            end
            OP_LOAD: begin
                w_ctl_raw.alusrc   = 1'b1;
                w_ctl_raw.memtoreg = 1'b1;
                w_ctl_raw.regwrite = 1'b1;
                w_ctl_raw.memread  = 1'b1;
                w_ctl_raw.aluop    = ALUOP_MEM;
            end
            OP_STORE: begin
                w_ctl_raw.alusrc   = 1'b1;
                w_ctl_raw.memwrite = 1'b1;
                w_ctl_raw.aluop    = ALUOP_MEM;
            end
            OP_BRANCH: begin
                w_ctl_raw.branch   = 1'b1;
                w_ctl_raw.aluop    = ALUOP_BRANCH;
            end
            OP_JAL: begin
                w_ctl_raw.regwrite = 1'b1;
                w_ctl_raw.jal      = 1'b1;
            end
            OP_JALR: begin
                w_ctl_raw.alusrc   = 1'b1;
                w_ctl_raw.regwrite = 1'b1;
                w_ctl_raw.jalr     = 1'b1;
            end
            OP_LUI: begin
                w_ctl_raw.alusrc   = 1'b1;
                w_ctl_raw.regwrite = 1'b1;
                w_ctl_raw.lui      = 1'b1;
            end
            OP_AUIPC: begin
                w_ctl_raw.alusrc   = 1'b1;
                w_ctl_raw.regwrite = 1'b1;
                w_ctl_raw.auipc    = 1'b1;
            end
            default: begin
                w_known = 1'b0;
            end
        endcase
    end

`ifdef ILLEGAL_DETECT_EN
    logic w_bad_funct7;
    logic w_bad_reg;

    function automatic logic reg_bad(input logic [4:0] a);
        return ({1'b0, a} >= c_nreg);
    endfunction

    // Only the register fields a format actually uses are range-checked, so
    // immediate bits that overlay rs2/rd never raise a false illegal flag.
    always_comb begin
        w_bad_funct7 = (w_opcode == OP_R) &&
                       (i_instruction[31:25] != 7'b0000000) &&
                       (i_instruction[31:25] != 7'b0100000);
        w_bad_reg = 1'b0;
        case (w_opcode)
            OP_R:
                w_bad_reg = reg_bad(i_instruction[11:7]) || reg_bad(i_instruction[19:15]) ||
                            reg_bad(i_instruction[24:20]);
            OP_IMM, OP_LOAD, OP_JALR:
                w_bad_reg = reg_bad(i_instruction[11:7]) || reg_bad(i_instruction[19:15]);
            OP_STORE, OP_BRANCH:
                w_bad_reg = reg_bad(i_instruction[19:15]) || reg_bad(i_instruction[24:20]);
            OP_JAL, OP_LUI, OP_AUIPC:
                w_bad_reg = reg_bad(i_instruction[11:7]);
            default:
                w_bad_reg = 1'b0;
        endcase
    end

    assign o_illegal = !w_known || w_bad_funct7 || w_bad_reg;
    assign o_ctl     = o_illegal ? CTL_NOP : w_ctl_raw;
`else
    assign o_illegal = 1'b0;
    assign o_ctl     = w_ctl_raw;
`endif

    // Bits not needed by every build configuration
    assign w_unused = &{1'b0, i_instruction, c_nreg, w_known};

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : RV32 decode stage: register file with writeback bypass,
//               control decode, immediate generation and a valid-tracked
//               ID/EX register with EX back-pressure hold and writeback
//               refresh of held operands.
//               Optional macro: ILLEGAL_DETECT_EN (illegal-instruction flag).
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int RF_PRELOAD = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [XLEN-1:0] PC_in,
    input  logic [31:0]     instruction_in,
    input  logic            stall,
    input  logic            flush,
    input  logic            ex_hold,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    output logic [XLEN-1:0] PC_out,
    output logic [XLEN-1:0] ReadData1_out,
    output logic [XLEN-1:0] ReadData2_out,
    output logic [XLEN-1:0] Immediate_out,
    output logic [4:0]      Rd_out,
    output logic [4:0]      Rs1_out,
    output logic [4:0]      Rs2_out,
    output logic [2:0]      funct3_out,
    output logic [6:0]      funct7_out,
    output logic            Ctl_ALUSrc_out,
    output logic            Ctl_MemtoReg_out,
    output logic            Ctl_RegWrite_out,
    output logic            Ctl_MemRead_out,
    output logic            Ctl_MemWrite_out,
    output logic            Ctl_Branch_out,
    output logic [1:0]      Ctl_ALUOp_out,
    output logic            jal_out,
    output logic            jalr_out,
    output logic            lui_out,
    output logic            auipc_out,
    output logic            illegal_out
);

    localparam logic [5:0] c_nreg = 6'(NREG);

    // Storage is always 32 deep so 5-bit indexing is width-exact; entries at
    // or above NREG are never written and stay at their constant reset value.
    logic [XLEN-1:0] r_rf [0:31];

    logic [4:0]      w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0] w_rd1, w_rd2, w_imm;
    logic [31:0]     w_imm32;
    logic            w_wr_ok, w_live, w_illegal;
    ctl_t            w_ctl;

    logic            r_valid, r_illegal;
    ctl_t            r_ctl;
    logic [XLEN-1:0] r_pc, r_rd1, r_rd2, r_imm;
    logic [4:0]      r_rd, r_rs1, r_rs2;
    logic [2:0]      r_funct3;
    logic [6:0]      r_funct7;

    function automatic logic addr_ok(input logic [4:0] a);
        return ({1'b0, a} < c_nreg);
    endfunction

    assign w_rs1   = instruction_in[19:15];
    assign w_rs2   = instruction_in[24:20];
    assign w_rd    = instruction_in[11:7];
    assign w_wr_ok = wb_en && (wb_addr != 5'd0) && addr_ok(wb_addr);
    assign w_live  = in_valid && !stall && !flush;
    assign w_imm32 = gen_imm(instruction_in);

    generate
        if (XLEN > 32) begin : g_imm_wide
            assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_imm_narrow
            assign w_imm = w_imm32[XLEN-1:0];
        end
    endgenerate

    decode_ctl #(
        .NREG (NREG)
    ) u_ctl (
        .i_instruction (instruction_in),
        .o_ctl         (w_ctl),
        .o_illegal     (w_illegal)
    );

    // Register file: optional preload on reset, x0 and out-of-range writes dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                r_rf[i] <= (RF_PRELOAD != 0 && i >= 1 && i <= 6) ? XLEN'(i + 1) : '0;
            end
        end else if (w_wr_ok) begin
            r_rf[wb_addr] <= wb_data;
        end
    end

    // Read ports with same-cycle writeback bypass; x0 never bypasses
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (addr_ok(w_rs1)) begin
            w_rd1 = (wb_en && wb_addr == w_rs1 && wb_addr != 5'd0) ? wb_data : r_rf[w_rs1];
        end
        if (addr_ok(w_rs2)) begin
            w_rd2 = (wb_en && wb_addr == w_rs2 && wb_addr != 5'd0) ? wb_data : r_rf[w_rs2];
        end
    end

    // ID/EX register: flush beats hold; hold refreshes operands from writeback
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_ctl     <= CTL_NOP;
            r_pc      <= '0;
            r_rd1     <= '0;
            r_rd2     <= '0;
            r_imm     <= '0;
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_funct3  <= '0;
            r_funct7  <= '0;
        end else if (ex_hold && !flush) begin
            if (r_valid && wb_en && wb_addr != 5'd0 && wb_addr == r_rs1) begin
                r_rd1 <= wb_data;
            end
            if (r_valid && wb_en && wb_addr != 5'd0 && wb_addr == r_rs2) begin
                r_rd2 <= wb_data;
            end
        end else begin
            r_valid   <= w_live;
            r_illegal <= w_live && w_illegal;
            r_ctl     <= w_live ? w_ctl : CTL_NOP;
            r_pc      <= PC_in;
            r_rd1     <= w_rd1;
            r_rd2     <= w_rd2;
            r_imm     <= w_imm;
            r_rd      <= w_rd;
            r_rs1     <= w_rs1;
            r_rs2     <= w_rs2;
            r_funct3  <= instruction_in[14:12];
            r_funct7  <= instruction_in[31:25];
        end
    end

    assign out_valid        = r_valid;
    assign PC_out           = r_pc;
    assign ReadData1_out    = r_rd1;
    assign ReadData2_out    = r_rd2;
    assign Immediate_out    = r_imm;
    assign Rd_out           = r_rd;
    assign Rs1_out          = r_rs1;
    assign Rs2_out          = r_rs2;
    assign funct3_out       = r_funct3;
    assign funct7_out       = r_funct7;
    assign Ctl_ALUSrc_out   = r_ctl.alusrc;
    assign Ctl_MemtoReg_out = r_ctl.memtoreg;
    assign Ctl_RegWrite_out = r_ctl.regwrite;
    assign Ctl_MemRead_out  = r_ctl.memread;
    assign Ctl_MemWrite_out = r_ctl.memwrite;
    assign Ctl_Branch_out   = r_ctl.branch;
    assign Ctl_ALUOp_out    = r_ctl.aluop;
    assign jal_out          = r_ctl.jal;
    assign jalr_out         = r_ctl.jalr;
    assign lui_out          = r_ctl.lui;
    assign auipc_out        = r_ctl.auipc;
    assign illegal_out      = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Directed self-checking bench for decode_stage (RV32I instance
//               plus an RV32E instance for register-range behaviour).
//               Honours ILLEGAL_DETECT_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    // {valid, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop, jal, jalr, lui, auipc, illegal}
    localparam logic [13:0] C_R     = 14'b1_001000_10_0000_0;
    localparam logic [13:0] C_I     = 14'b1_101000_11_0000_0;
    localparam logic [13:0] C_LD    = 14'b1_111100_00_0000_0;
    localparam logic [13:0] C_ST    = 14'b1_100010_00_0000_0;
    localparam logic [13:0] C_BR    = 14'b1_000001_01_0000_0;
    localparam logic [13:0] C_JAL   = 14'b1_001000_00_1000_0;
    localparam logic [13:0] C_JALR  = 14'b1_101000_00_0100_0;
    localparam logic [13:0] C_LUI   = 14'b1_101000_00_0010_0;
    localparam logic [13:0] C_AUIPC = 14'b1_101000_00_0001_0;
    localparam logic [13:0] C_BUB   = 14'b0;
`ifdef ILLEGAL_DETECT_EN
    localparam logic [13:0] C_ILL   = 14'b1_000000_00_0000_1;
    localparam logic [13:0] C_F7    = C_ILL;
    localparam logic [13:0] C_E17   = C_ILL;
`else
    localparam logic [13:0] C_ILL   = 14'b1_000000_00_0000_0;
    localparam logic [13:0] C_F7    = C_R;
    localparam logic [13:0] C_E17   = C_R;
`endif

    localparam logic [31:0] IMM_INST [8] = '{32'hFE000CE3, 32'h123450B7, 32'h0020A423, 32'h010000EF,
                                             32'hFFFFF06F, 32'h00001297, 32'hFFC12303, 32'h00008067};
    localparam logic [31:0] IMM_EXP  [8] = '{32'hFFFFFFF8, 32'h12345000, 32'h00000008, 32'h00000010,
                                             32'hFFFFFFFE, 32'h00001000, 32'hFFFFFFFC, 32'h00000000};
    localparam logic [13:0] IMM_OBS  [8] = '{C_BR, C_LUI, C_ST, C_JAL, C_JAL, C_AUIPC, C_LD, C_JALR};

    logic        clk = 1'b0;
    logic        reset, in_valid, stall, flush, ex_hold, wb_en;
    logic [31:0] PC_in, instruction_in, wb_data;
    logic [4:0]  wb_addr;

    logic        out_valid, Ctl_ALUSrc_out, Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out;
    logic        Ctl_MemWrite_out, Ctl_Branch_out, jal_out, jalr_out, lui_out, auipc_out, illegal_out;
    logic [1:0]  Ctl_ALUOp_out;
    logic [31:0] PC_out, ReadData1_out, ReadData2_out, Immediate_out;
    logic [4:0]  Rd_out, Rs1_out, Rs2_out;
    logic [2:0]  funct3_out;
    logic [6:0]  funct7_out;

    logic        e_valid, e_alusrc, e_memtoreg, e_regwrite, e_memread, e_memwrite, e_branch;
    logic        e_jal, e_jalr, e_lui, e_auipc, e_illegal;
    logic [1:0]  e_aluop;
    logic [31:0] e_pc, e_rd1, e_rd2, e_imm;
    logic [4:0]  e_rd, e_rs1, e_rs2;
    logic [2:0]  e_funct3;
    logic [6:0]  e_funct7;

    logic [13:0] obs, e_obs;
    logic        e_sink_unused;
    int          vectors = 0;
    int          miscompares = 0;

    assign obs = {out_valid, Ctl_ALUSrc_out, Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out,
                  Ctl_MemWrite_out, Ctl_Branch_out, Ctl_ALUOp_out, jal_out, jalr_out, lui_out,
                  auipc_out, illegal_out};
    assign e_obs = {e_valid, e_alusrc, e_memtoreg, e_regwrite, e_memread, e_memwrite, e_branch,
                    e_aluop, e_jal, e_jalr, e_lui, e_auipc, e_illegal};
    assign e_sink_unused = ^{e_pc, e_imm, e_rd, e_rs1, e_rs2, e_funct3, e_funct7};

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .NREG(32), .RF_PRELOAD(1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .PC_in(PC_in), .instruction_in(instruction_in),
        .stall(stall), .flush(flush), .ex_hold(ex_hold), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .PC_out(PC_out), .ReadData1_out(ReadData1_out), .ReadData2_out(ReadData2_out),
        .Immediate_out(Immediate_out), .Rd_out(Rd_out), .Rs1_out(Rs1_out), .Rs2_out(Rs2_out),
        .funct3_out(funct3_out), .funct7_out(funct7_out), .Ctl_ALUSrc_out(Ctl_ALUSrc_out),
        .Ctl_MemtoReg_out(Ctl_MemtoReg_out), .Ctl_RegWrite_out(Ctl_RegWrite_out),
        .Ctl_MemRead_out(Ctl_MemRead_out), .Ctl_MemWrite_out(Ctl_MemWrite_out),
        .Ctl_Branch_out(Ctl_Branch_out), .Ctl_ALUOp_out(Ctl_ALUOp_out), .jal_out(jal_out),
        .jalr_out(jalr_out), .lui_out(lui_out), .auipc_out(auipc_out), .illegal_out(illegal_out)
    );

    decode_stage #(.XLEN(32), .NREG(16), .RF_PRELOAD(1)) u_dut_e (
        .clk(clk), .reset(reset), .in_valid(in_valid), .PC_in(PC_in), .instruction_in(instruction_in),
        .stall(stall), .flush(flush), .ex_hold(ex_hold), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(e_valid), .PC_out(e_pc), .ReadData1_out(e_rd1), .ReadData2_out(e_rd2),
        .Immediate_out(e_imm), .Rd_out(e_rd), .Rs1_out(e_rs1), .Rs2_out(e_rs2),
        .funct3_out(e_funct3), .funct7_out(e_funct7), .Ctl_ALUSrc_out(e_alusrc),
        .Ctl_MemtoReg_out(e_memtoreg), .Ctl_RegWrite_out(e_regwrite),
        .Ctl_MemRead_out(e_memread), .Ctl_MemWrite_out(e_memwrite),
        .Ctl_Branch_out(e_branch), .Ctl_ALUOp_out(e_aluop), .jal_out(e_jal),
        .jalr_out(e_jalr), .lui_out(e_lui), .auipc_out(e_auipc), .illegal_out(e_illegal)
    );

    // Advance to just past the next rising edge
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst);
        in_valid       = 1'b1;
        instruction_in = inst;
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; flush = 1'b0; ex_hold = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; PC_in = 32'h100;
        drive(32'h002083B3);
        repeat (2) cycle();
        vectors++; if (obs !== C_BUB) begin miscompares++; $display("FAIL reset_ctl: got %b want %b", obs, C_BUB); end
        vectors++; if ({PC_out, ReadData1_out, ReadData2_out, Immediate_out, Rd_out, Rs1_out, Rs2_out, funct3_out, funct7_out} !== '0) begin
            miscompares++; $display("FAIL reset_data: got pc=%h rd1=%h rd2=%h imm=%h want all zero", PC_out, ReadData1_out, ReadData2_out, Immediate_out);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        cycle();
        vectors++; if (obs !== C_R) begin miscompares++; $display("FAIL basic_ctl: got %b want %b", obs, C_R); end
        vectors++; if (ReadData1_out !== 32'd2) begin miscompares++; $display("FAIL basic_rd1: got %h want %h", ReadData1_out, 32'd2); end
        vectors++; if (ReadData2_out !== 32'd3) begin miscompares++; $display("FAIL basic_rd2: got %h want %h", ReadData2_out, 32'd3); end
        vectors++; if ({PC_out, Rd_out, Immediate_out} !== {32'h100, 5'd7, 32'd0}) begin
            miscompares++; $display("FAIL basic_fields: got pc=%h rd=%0d imm=%h want pc=100 rd=7 imm=0", PC_out, Rd_out, Immediate_out);
        end
    endtask

    task automatic test_bypass();
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h55;
        drive(32'h002083B3);
        cycle();
        vectors++; if (ReadData1_out !== 32'h55) begin miscompares++; $display("FAIL bypass_x1: got %h want %h", ReadData1_out, 32'h55); end
        wb_addr = 5'd0;
        drive(32'h002003B3);
        cycle();
        vectors++; if (ReadData1_out !== 32'd0) begin miscompares++; $display("FAIL bypass_x0: got %h want %h", ReadData1_out, 32'd0); end
        wb_en = 1'b0;
        cycle();
        vectors++; if (ReadData1_out !== 32'd0) begin miscompares++; $display("FAIL x0_write_ignored: got %h want %h", ReadData1_out, 32'd0); end
    endtask

    task automatic test_hold();
        drive(32'h00520433);
        cycle();
        vectors++; if ({ReadData1_out, ReadData2_out, Rs2_out} !== {32'd5, 32'd6, 5'd5}) begin
            miscompares++; $display("FAIL hold_load: got rd1=%h rd2=%h rs2=%0d want 5 6 5", ReadData1_out, ReadData2_out, Rs2_out);
        end
        ex_hold = 1'b1;
        drive(32'hFFF08193);
        cycle();
        vectors++; if ({obs, Rd_out, ReadData2_out} !== {C_R, 5'd8, 32'd6}) begin
            miscompares++; $display("FAIL hold_c1: got ctl=%b rd=%0d rd2=%h want %b 8 6", obs, Rd_out, ReadData2_out, C_R);
        end
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hAA;
        cycle();
        vectors++; if (ReadData2_out !== 32'hAA) begin miscompares++; $display("FAIL hold_refresh: got %h want %h", ReadData2_out, 32'hAA); end
        vectors++; if ({ReadData1_out, Rd_out, Immediate_out, PC_out} !== {32'd5, 5'd8, 32'd0, 32'h100}) begin
            miscompares++; $display("FAIL hold_c2: got rd1=%h rd=%0d imm=%h pc=%h want 5 8 0 100", ReadData1_out, Rd_out, Immediate_out, PC_out);
        end
        wb_en = 1'b0;
        cycle();
        vectors++; if ({obs, ReadData2_out, Rs2_out} !== {C_R, 32'hAA, 5'd5}) begin
            miscompares++; $display("FAIL hold_c3: got ctl=%b rd2=%h rs2=%0d want %b aa 5", obs, ReadData2_out, Rs2_out, C_R);
        end
        ex_hold = 1'b0;
        cycle();
        vectors++; if ({obs, Immediate_out, ReadData1_out, Rd_out} !== {C_I, 32'hFFFFFFFF, 32'h55, 5'd3}) begin
            miscompares++; $display("FAIL hold_release: got ctl=%b imm=%h rd1=%h rd=%0d want %b ffffffff 55 3", obs, Immediate_out, ReadData1_out, Rd_out, C_I);
        end
    endtask

    task automatic test_immediates();
        for (int k = 0; k < 8; k++) begin
            drive(IMM_INST[k]);
            cycle();
            vectors++; if (Immediate_out !== IMM_EXP[k]) begin miscompares++; $display("FAIL imm_%0d: got %h want %h", k, Immediate_out, IMM_EXP[k]); end
            vectors++; if (obs !== IMM_OBS[k]) begin miscompares++; $display("FAIL imm_ctl_%0d: got %b want %b", k, obs, IMM_OBS[k]); end
        end
    endtask

    task automatic test_flush();
        drive(32'h002083B3);
        cycle();
        flush = 1'b1; ex_hold = 1'b1;
        cycle();
        vectors++; if (obs !== C_BUB) begin miscompares++; $display("FAIL flush_over_hold: got %b want %b", obs, C_BUB); end
        flush = 1'b0;
        cycle();
        vectors++; if (obs !== C_BUB) begin miscompares++; $display("FAIL flush_then_hold: got %b want %b", obs, C_BUB); end
        ex_hold = 1'b0;
    endtask

    task automatic test_stall();
        stall = 1'b1; wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
        drive(32'h00048533);
        cycle();
        vectors++; if (obs !== C_BUB) begin miscompares++; $display("FAIL stall_bubble: got %b want %b", obs, C_BUB); end
        stall = 1'b0; wb_en = 1'b0;
        cycle();
        vectors++; if ({obs, ReadData1_out} !== {C_R, 32'h99}) begin
            miscompares++; $display("FAIL stall_wb_kept: got ctl=%b rd1=%h want %b 99", obs, ReadData1_out, C_R);
        end
        in_valid = 1'b0;
        cycle();
        vectors++; if (obs !== C_BUB) begin miscompares++; $display("FAIL invalid_bubble: got %b want %b", obs, C_BUB); end
    endtask

    task automatic test_illegal();
        drive(32'h0000007F);
        cycle();
        vectors++; if ({obs, Immediate_out} !== {C_ILL, 32'd0}) begin
            miscompares++; $display("FAIL illegal_opcode: got ctl=%b imm=%h want %b 0", obs, Immediate_out, C_ILL);
        end
        drive(32'h022083B3);
        cycle();
        vectors++; if (obs !== C_F7) begin miscompares++; $display("FAIL illegal_funct7: got %b want %b", obs, C_F7); end
        in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd17; wb_data = 32'h77;
        cycle();
        wb_en = 1'b0;
        drive(32'h002883B3);
        cycle();
        vectors++; if ({obs, ReadData1_out} !== {C_R, 32'h77}) begin
            miscompares++; $display("FAIL rv32i_x17: got ctl=%b rd1=%h want %b 77", obs, ReadData1_out, C_R);
        end
        vectors++; if ({e_obs, e_rd1, e_rd2} !== {C_E17, 32'd0, 32'd3}) begin
            miscompares++; $display("FAIL rv32e_x17: got ctl=%b rd1=%h rd2=%h want %b 0 3", e_obs, e_rd1, e_rd2, C_E17);
        end
    endtask

    task automatic test_async_reset();
        drive(32'h002083B3);
        cycle();
        ex_hold = 1'b1;
        cycle();
        #2 reset = 1'b0;
        #1;
        vectors++; if ({obs, ReadData1_out, PC_out} !== {C_BUB, 32'd0, 32'd0}) begin
            miscompares++; $display("FAIL async_reset: got ctl=%b rd1=%h pc=%h want all zero", obs, ReadData1_out, PC_out);
        end
        cycle();
        reset = 1'b1; ex_hold = 1'b0;
        cycle();
        vectors++; if ({obs, ReadData1_out, ReadData2_out} !== {C_R, 32'd2, 32'd3}) begin
            miscompares++; $display("FAIL reset_preload: got ctl=%b rd1=%h rd2=%h want %b 2 3", obs, ReadData1_out, ReadData2_out, C_R);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_hold();
        test_immediates();
        test_flush();
        test_stall();
        test_illegal();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
